// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and load/store.
// Each access runs IDLE -> ACCESS (MEM_LAT cycles) -> RESP -> IDLE.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [1:0]        d_size,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [1:0]        mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              stall
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } stateT;

   stateT         state;
   stateT         nextState;
   logic          ownData;
   logic          latWr;
   logic [CW-1:0] cnt;
   logic [SW-1:0] starveCnt;
   logic          starveFull;
   logic          pickFetch;
   logic          pickData;

   assign starveFull = (starveCnt == SW'(STARVE_MAX));

   // Owner selection, grants, memory strobes and next state.
   always_comb begin
      nextState = state;
      pickFetch = if_req & (~d_req | starveFull);
      pickData  = d_req & ~pickFetch;
      if_gnt    = (state == IDLE) & pickFetch;
      d_gnt     = (state == IDLE) & pickData;
      mem_en    = (state == ACCESS);
      mem_wr    = (state == ACCESS) & latWr;
      if_done   = (state == RESP) & ~ownData;
      d_done    = (state == RESP) & ownData;
      busy      = (state != IDLE);
      stall     = (if_req & ~if_gnt) | (d_req & ~d_gnt);
      unique case (state)
         IDLE:    if (if_gnt | d_gnt) nextState = ACCESS;
         ACCESS:  if (cnt == '0) nextState = RESP;
         RESP:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // State, latched request, latency count, read data and starve count.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ownData   <= 1'b0;
         latWr     <= 1'b0;
         cnt       <= '0;
         starveCnt <= '0;
         mem_size  <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         state <= nextState;
         unique case (state)
            IDLE: begin
               if (if_gnt | d_gnt) begin
                  ownData   <= d_gnt;
                  latWr     <= d_gnt & d_wr;
                  mem_size  <= d_gnt ? d_size : 2'd2;
                  mem_addr  <= d_gnt ? d_addr : if_addr;
                  mem_wdata <= d_gnt ? d_wdata : '0;
                  cnt       <= CW'(MEM_LAT - 1);
               end
               if (if_gnt)
                  starveCnt <= '0;
               else if (d_gnt & if_req) begin
                  if (!starveFull) starveCnt <= starveCnt + SW'(1);
               end else if (!if_req)
                  starveCnt <= '0;
            end
            ACCESS: begin
               if (cnt == '0) begin
                  if (!latWr) begin
                     if (ownData) d_rdata  <= mem_rdata;
                     else         if_rdata <= mem_rdata;
                  end
               end else
                  cnt <= cnt - CW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random fetch/data traffic,
// starvation pattern and reset in the middle of an access.
module tb_mem_port_arbiter;

   localparam int MEM_LAT    = 2;
   localparam int STARVE_MAX = 4;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        d_req;
   logic        d_wr;
   logic [1:0]  d_size;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        mem_en;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        stall;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rdata(if_rdata), .if_done(if_done),
      .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rdata(d_rdata), .d_done(d_done),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .stall(stall)
   );

   function automatic logic [31:0] memFn(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   assign mem_rdata = mem_en ? memFn(mem_addr) : 32'h0;

   typedef struct {
      bit          isData;
      bit          wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          doneCyc;
   } txnT;

   txnT sb[$];
   bit  glog[$];
   int  rdIdx;
   int  cyc;
   int  nCmp;
   int  nErr;
   bit  modelOn;
   bit  monOn;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference arbiter: one access per MEM_LAT+2 cycles, data wins
   // unless fetch has been passed over STARVE_MAX times.
   task automatic modelLoop();
      int freeAt = 0;
      int starve = 0;
      bit eIf;
      bit eD;
      bit eBusy;
      txnT t;
      forever begin
         @(negedge clk);
         #2;
         if (modelOn && !reset) begin
            eIf   = 0;
            eD    = 0;
            eBusy = (cyc < freeAt);
            if (!eBusy) begin
               if (if_req && (!d_req || starve == STARVE_MAX)) eIf = 1;
               else if (d_req) eD = 1;
               if (eIf) starve = 0;
               else if (eD && if_req)
                  starve = (starve < STARVE_MAX) ? starve + 1 : starve;
               else if (!if_req) starve = 0;
               if (eIf || eD) begin
                  t.isData  = eD;
                  t.wr      = eD && d_wr;
                  t.size    = eD ? d_size : 2'd2;
                  t.addr    = eD ? d_addr : if_addr;
                  t.wdata   = d_wdata;
                  t.doneCyc = cyc + MEM_LAT + 1;
                  sb.push_back(t);
                  glog.push_back(eIf);
                  freeAt = cyc + MEM_LAT + 2;
               end
            end
            chk("if_gnt", 32'(if_gnt), 32'(eIf));
            chk("d_gnt", 32'(d_gnt), 32'(eD));
            chk("busy", 32'(busy), 32'(eBusy));
            chk("stall", 32'(stall),
                32'((if_req && !eIf) || (d_req && !eD)));
         end
      end
   endtask

   // Monitor: checks memory-side activity and completions against the queue.
   task automatic monLoop();
      int memCnt = 0;
      logic [31:0] expIfR = 0;
      logic [31:0] expDR = 0;
      txnT t;
      forever begin
         @(negedge clk);
         #3;
         if (monOn) begin
            if (mem_en) begin
               if (rdIdx < sb.size()) begin
                  t = sb[rdIdx];
                  chk("mem_addr", mem_addr, t.addr);
                  chk("mem_wr", 32'(mem_wr), 32'(t.wr));
                  chk("mem_size", 32'(mem_size), 32'(t.size));
                  if (t.wr) chk("mem_wdata", mem_wdata, t.wdata);
               end else
                  chk("mem_en without txn", 32'(mem_en), 32'h0);
               memCnt++;
            end
            if (if_done && d_done) chk("both done", 32'h1, 32'h0);
            if (if_done || d_done) begin
               if (rdIdx < sb.size()) begin
                  t = sb[rdIdx];
                  chk("done owner", 32'(d_done), 32'(t.isData));
                  chk("done cycle", 32'(cyc), 32'(t.doneCyc));
                  chk("mem cycles", 32'(memCnt), 32'(MEM_LAT));
                  if (!t.isData) expIfR = memFn(t.addr);
                  else if (!t.wr) expDR = memFn(t.addr);
                  chk("if_rdata", if_rdata, expIfR);
                  chk("d_rdata", d_rdata, expDR);
                  rdIdx++;
               end else
                  chk("done without txn", 32'h1, 32'h0);
               memCnt = 0;
            end
         end
      end
   endtask

   task automatic fetchDrv(input int n, input int gapMax, input bit mayDrop);
      int w;
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(gapMax, 0)) begin
            if_req = 1'b0;
            @(negedge clk);
         end
         if_req  = 1'b1;
         if_addr = $urandom & 32'h0000FFFC;
         for (w = 0; w < 300; w++) begin
            #1;
            if (if_gnt) begin
               @(negedge clk);
               break;
            end
            if (mayDrop && $urandom_range(7, 0) == 0) begin
               if_req = 1'b0;
               @(negedge clk);
               break;
            end
            @(negedge clk);
         end
         if (w == 300) chk("fetch wait bound", 32'h1, 32'h0);
      end
      if_req = 1'b0;
   endtask

   task automatic dataDrv(input int n, input int gapMax, input bit mayDrop);
      int w;
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(gapMax, 0)) begin
            d_req = 1'b0;
            @(negedge clk);
         end
         d_req   = 1'b1;
         d_wr    = 1'($urandom_range(1, 0));
         d_size  = 2'($urandom_range(2, 0));
         d_addr  = $urandom & 32'h0000FFFC;
         d_wdata = $urandom;
         for (w = 0; w < 300; w++) begin
            #1;
            if (d_gnt) begin
               @(negedge clk);
               break;
            end
            if (mayDrop && $urandom_range(7, 0) == 0) begin
               d_req = 1'b0;
               @(negedge clk);
               break;
            end
            @(negedge clk);
         end
         if (w == 300) chk("data wait bound", 32'h1, 32'h0);
      end
      d_req = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         if (rdIdx == sb.size() && !busy) break;
         @(negedge clk);
      end
      chk("drain", 32'(rdIdx == sb.size()), 32'h1);
   endtask

   initial begin
      bit expLog[6];
      expLog  = '{0, 0, 0, 0, 1, 0};
      reset   = 1'b1;
      if_req  = 1'b0;
      if_addr = '0;
      d_req   = 1'b0;
      d_wr    = 1'b0;
      d_size  = '0;
      d_addr  = '0;
      d_wdata = '0;
      cyc     = 0;
      nCmp    = 0;
      nErr    = 0;
      rdIdx   = 0;
      modelOn = 0;
      monOn   = 0;
      fork
         forever @(posedge clk) cyc <= cyc + 1;
         modelLoop();
         monLoop();
      join_none

      repeat (3) @(negedge clk);
      chk("rst mem_en", 32'(mem_en), 32'h0);
      chk("rst busy", 32'(busy), 32'h0);
      chk("rst mem_addr", mem_addr, 32'h0);
      chk("rst if_rdata", if_rdata, 32'h0);
      chk("rst d_rdata", d_rdata, 32'h0);
      chk("rst dones", 32'({if_done, d_done}), 32'h0);
      reset   = 1'b0;
      modelOn = 1;
      monOn   = 1;
      @(negedge clk);

      fork
         fetchDrv(40, 4, 1);
         dataDrv(40, 4, 1);
      join
      drain();

      glog.delete();
      fork
         fetchDrv(3, 0, 0);
         dataDrv(12, 0, 0);
      join
      drain();
      chk("starve log len", 32'(glog.size() >= 6), 32'h1);
      if (glog.size() >= 6)
         for (int i = 0; i < 6; i++)
            chk($sformatf("starve grant %0d", i), 32'(glog[i]),
                32'(expLog[i]));

      modelOn = 0;
      monOn   = 0;
      @(negedge clk);
      d_req  = 1'b1;
      d_wr   = 1'b0;
      d_size = 2'd2;
      d_addr = 32'h200;
      #1;
      chk("rst-load d_gnt", 32'(d_gnt), 32'h1);
      @(negedge clk);
      d_req = 1'b0;
      chk("rst-load mem_en", 32'(mem_en), 32'h1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid-rst mem_en", 32'(mem_en), 32'h0);
      chk("mid-rst busy", 32'(busy), 32'h0);
      chk("mid-rst mem_addr", mem_addr, 32'h0);
      chk("mid-rst d_rdata", d_rdata, 32'h0);
      chk("mid-rst if_rdata", if_rdata, 32'h0);
      chk("mid-rst mem_size", 32'(mem_size), 32'h0);
      repeat (3) begin
         chk("mid-rst no done", 32'({if_done, d_done, mem_en}), 32'h0);
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
